// File: rtl/serial_sub_pkg.sv
`default_nettype none
// ============================================================================
// Module      : serial_sub_pkg
// Description : Shared FSM state encoding for the bit-serial subtractor.
// Revision    : 1.0 - initial release
// ============================================================================
package serial_sub_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/fs_cell.sv
`default_nettype none
// ============================================================================
// Module      : fs_cell
// Description : 1-bit full subtractor: d = a - b - bin, bo = borrow out.
// Revision    : 1.0 - initial release
// ============================================================================
module fs_cell (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bo
);

    // Borrow when a=0,b=1, or when a==b and a borrow is already pending.
    always_comb begin
        d  = a ^ b ^ bin;
        bo = (~a & b) | (~(a ^ b) & bin);
    end

endmodule
`default_nettype wire

// File: rtl/serial_subtractor.sv
`default_nettype none
// ============================================================================
// Module      : serial_subtractor
// Description : Bit-serial subtractor, LSB first, one bit per clock.
//               {bout, diff} = a - b - bin, result after WIDTH shift cycles.
// Revision    : 1.0 - initial release
// ============================================================================
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout
);

    import serial_sub_pkg::*;

    localparam int               CNT_W  = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] C_LAST = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] C_ONE  = CNT_W'(1);

    state_t             r_state;
    state_t             w_next;
    logic               w_load;
    logic               w_shift;

    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [WIDTH-1:0]   r_diff;
    logic               r_br;
    logic [CNT_W-1:0]   r_cnt;

    logic               w_d;
    logic               w_bo;

    // The only arithmetic in the datapath: one bit of the subtraction per cycle.
    fs_cell u_fs_cell (
        .a   (r_a[0]),
        .b   (r_b[0]),
        .bin (r_br),
        .d   (w_d),
        .bo  (w_bo)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state and control decode; DONE may accept a new operation directly.
    always_comb begin
        w_next  = r_state;
        w_load  = 1'b0;
        w_shift = 1'b0;
        busy    = 1'b0;
        done    = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_load = 1'b1;
                    w_next = SHIFT;
                end
            end
            SHIFT: begin
                busy    = 1'b1;
                w_shift = 1'b1;
                if (r_cnt == C_LAST) begin
                    w_next = DONE;
                end
            end
            DONE: begin
                done = 1'b1;
                if (start) begin
                    w_load = 1'b1;
                    w_next = SHIFT;
                end else begin
                    w_next = IDLE;
                end
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    // Operand/result shift registers; the borrow register doubles as bout,
    // so after the last shift it already holds the final borrow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a    <= '0;
            r_b    <= '0;
            r_diff <= '0;
            r_br   <= 1'b0;
            r_cnt  <= '0;
        end else if (w_load) begin
            r_a    <= a;
            r_b    <= b;
            r_br   <= bin;
            r_cnt  <= '0;
        end else if (w_shift) begin
            r_diff <= {w_d, r_diff[WIDTH-1:1]};
            r_a    <= r_a >> 1;
            r_b    <= r_b >> 1;
            r_br   <= w_bo;
            r_cnt  <= r_cnt + C_ONE;
        end
    end

    assign diff = r_diff;
    assign bout = r_br;

endmodule
`default_nettype wire

// File: tb/tb_serial_subtractor.sv
`default_nettype none
// ============================================================================
// Module      : tb_serial_subtractor
// Description : Self-checking bench for serial_subtractor (WIDTH=8 main,
//               WIDTH=2 exhaustive) with a transaction-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_subtractor;

    localparam int W = 8;

    logic         clk   = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] a     = '0;
    logic [W-1:0] b     = '0;
    logic         bin   = 1'b0;
    logic         busy;
    logic         done;
    logic [W-1:0] diff;
    logic         bout;

    logic         start2 = 1'b0;
    logic [1:0]   a2     = '0;
    logic [1:0]   b2     = '0;
    logic         bin2   = 1'b0;
    logic         busy2;
    logic         done2;
    logic [1:0]   diff2;
    logic         bout2;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    serial_subtractor #(.WIDTH(W)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .bin   (bin),
        .busy  (busy),
        .done  (done),
        .diff  (diff),
        .bout  (bout)
    );

    serial_subtractor #(.WIDTH(2)) u_dut2 (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start2),
        .a     (a2),
        .b     (b2),
        .bin   (bin2),
        .busy  (busy2),
        .done  (done2),
        .diff  (diff2),
        .bout  (bout2)
    );

    // Reference: {bout, diff} = a - b - bin modulo 2^(W+1).
    function automatic logic [W:0] ref_sub(input logic [W-1:0] x, input logic [W-1:0] y,
                                           input logic c);
        return {1'b0, x} - {1'b0, y} - {{W{1'b0}}, c};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Transaction-level model: phase, cycles left in the operation, and the
    // result that diff/bout are required to show while it is meaningful.
    int           m_phase = 0;   // 0 idle, 1 busy, 2 done
    int           m_left  = 0;
    logic [W:0]   m_pend  = '0;
    logic [W:0]   m_res   = '0;
    bit           m_valid = 1'b1;

    // Compare process: every falling edge, check outputs then predict the next edge.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                m_phase = 0;
                m_res   = '0;
                m_valid = 1'b1;
            end
            chk("sb_busy", 32'(busy), 32'(m_phase == 1));
            chk("sb_done", 32'(done), 32'(m_phase == 2));
            if (m_valid) begin
                chk("sb_diff", 32'(diff), 32'(m_res[W-1:0]));
                chk("sb_bout", 32'(bout), 32'(m_res[W]));
            end
            if (rst_n) begin
                if (m_phase == 1) begin
                    m_left--;
                    if (m_left == 0) begin
                        m_phase = 2;
                        m_res   = m_pend;
                        m_valid = 1'b1;
                    end
                end else if (start) begin
                    m_phase = 1;
                    m_left  = W;
                    m_pend  = ref_sub(a, b, bin);
                    m_valid = 1'b0;
                end else begin
                    m_phase = 0;
                end
            end
        end
    end

    // Poll for done with a cycle budget; counts busy cycles seen on the way.
    task automatic wait_done(output int nb, output bit ok);
        nb = 0;
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done) begin
                ok = 1'b1;
                break;
            end
            if (busy) nb++;
        end
    endtask

    // One start pulse, scrambled operands during SHIFT, literal result check.
    task automatic do_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic tc,
                         input logic [W-1:0] ed, input logic eb, input string nm);
        int nb;
        bit ok;
        @(posedge clk); #1;
        a = ta; b = tb_v; bin = tc; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        a = 8'($urandom); b = 8'($urandom); bin = 1'($urandom);
        wait_done(nb, ok);
        chk({nm, "_done"}, 32'(ok), 32'(1));
        chk({nm, "_busycyc"}, 32'(nb), 32'(W));
        chk({nm, "_diff"}, 32'(diff), 32'(ed));
        chk({nm, "_bout"}, 32'(bout), 32'(eb));
    endtask

    initial begin
        int  nb;
        bit  ok;
        int  ndone;
        logic [2:0] e2;
        logic [1:0] xa, xb;
        logic       xc;
        logic [4:0] v;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", 32'(busy), 32'(0));
        chk("rst_done", 32'(done), 32'(0));
        chk("rst_diff", 32'(diff), 32'(0));
        chk("rst_bout", 32'(bout), 32'(0));
        rst_n = 1'b1;

        do_op(8'h5A, 8'h3C, 1'b0, 8'h1E, 1'b0, "basic");
        do_op(8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, "under1");
        do_op(8'h00, 8'hFF, 1'b1, 8'h00, 1'b1, "underbin");
        do_op(8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, "eqbin");
        do_op(8'hFF, 8'h00, 1'b0, 8'hFF, 1'b0, "maxmin");

        // start during the 3rd SHIFT cycle must be ignored
        @(posedge clk); #1;
        a = 8'h5A; b = 8'h3C; bin = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        start = 1'b1; a = 8'hFF; b = 8'h00;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(nb, ok);
        chk("ignore_done", 32'(ok), 32'(1));
        chk("ignore_diff", 32'(diff), 32'(8'h1E));
        chk("ignore_bout", 32'(bout), 32'(0));

        // back-to-back: start held through DONE with new operands
        @(posedge clk); #1;
        a = 8'h5A; b = 8'h3C; bin = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (W) @(posedge clk);
        #1;
        chk("b2b_first_done", 32'(done), 32'(1));
        chk("b2b_first_diff", 32'(diff), 32'(8'h1E));
        start = 1'b1; a = 8'h10; b = 8'h01; bin = 1'b0;
        @(posedge clk); #1;
        start = 1'b0; a = 8'($urandom); b = 8'($urandom);
        chk("b2b_no_idle", 32'(busy), 32'(1));
        wait_done(nb, ok);
        chk("b2b_done", 32'(ok), 32'(1));
        chk("b2b_busycyc", 32'(nb), 32'(W));
        chk("b2b_diff", 32'(diff), 32'(8'h0F));
        chk("b2b_bout", 32'(bout), 32'(0));

        // reset in the 4th SHIFT cycle abandons the operation
        @(posedge clk); #1;
        a = 8'h5A; b = 8'h3C; bin = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("midrst_busy", 32'(busy), 32'(0));
        chk("midrst_done", 32'(done), 32'(0));
        chk("midrst_diff", 32'(diff), 32'(0));
        chk("midrst_bout", 32'(bout), 32'(0));
        @(posedge clk); #1;
        rst_n = 1'b1;
        ndone = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done) ndone++;
        end
        chk("midrst_nodone", 32'(ndone), 32'(0));
        do_op(8'h37, 8'h12, 1'b1, 8'h24, 1'b0, "postrst");

        // randomized traffic, occasional reset, checked by the model
        for (int i = 0; i < 1500; i++) begin
            @(posedge clk); #1;
            start = ($urandom_range(0, 3) == 0);
            a     = 8'($urandom);
            b     = 8'($urandom);
            bin   = 1'($urandom);
            rst_n = ($urandom_range(0, 399) != 0);
        end
        @(posedge clk); #1;
        start = 1'b0;
        rst_n = 1'b1;
        repeat (12) @(posedge clk);
        #1;

        // WIDTH=2 exhaustive table
        $display("WIDTH=2 table: a b bin | diff bout | want");
        for (int i = 0; i < 32; i++) begin
            v  = 5'(i);
            xa = v[4:3];
            xb = v[2:1];
            xc = v[0];
            e2 = {1'b0, xa} - {1'b0, xb} - {2'b00, xc};
            @(posedge clk); #1;
            a2 = xa; b2 = xb; bin2 = xc; start2 = 1'b1;
            @(posedge clk); #1;
            start2 = 1'b0;
            ok = 1'b0;
            for (int k = 0; k < 20; k++) begin
                @(negedge clk);
                if (done2) begin
                    ok = 1'b1;
                    break;
                end
            end
            $display("  %0d %0d %0d | %0d %0d | %0d %0d", xa, xb, xc, diff2, bout2,
                     e2[1:0], e2[2]);
            chk("w2_done", 32'(ok), 32'(1));
            chk("w2_diff", 32'(diff2), 32'(e2[1:0]));
            chk("w2_bout", 32'(bout2), 32'(e2[2]));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/serial_subtractor.md
SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning operand/difference width in bits (legal range 2..32).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port start  input  1  request to begin one subtraction; sampled on a rising clk edge.
REQ-005 SHALL have port a  input  WIDTH  minuend; sampled only on the accepting edge.
REQ-006 SHALL have port b  input  WIDTH  subtrahend; sampled only on the accepting edge.
REQ-007 SHALL have port bin  input  1  borrow-in; sampled only on the accepting edge.
REQ-008 SHALL have port busy  output  1  high while a subtraction is in progress (SHIFT state).
REQ-009 SHALL have port done  output  1  one-cycle pulse; result valid.
REQ-010 SHALL have port diff  output  WIDTH  difference result.
REQ-011 SHALL have port bout  output  1  final borrow-out.

Function
REQ-012 SHALL compute {bout, diff} = a - b - bin modulo 2^(WIDTH+1); bout=1 iff a < b + bin (unsigned).
REQ-013 SHALL process one bit per clock, LSB first, via a 1-bit full-subtractor cell plus a borrow register.
REQ-014 SHALL implement FSM states IDLE, SHIFT, DONE.
REQ-015 IDLE: start=1 -> load a, b into shift registers, borrow reg <= bin, bit counter <= 0, go SHIFT; else stay.
REQ-016 SHIFT: each edge SHALL compute d = a0^b0^br, br' = (~a0&b0)|(~(a0^b0)&br), shift d into diff register from MSB side, shift operands right, increment counter.
REQ-017 SHIFT: after the WIDTH-th bit edge SHALL go DONE, with diff/bout holding the final result.
REQ-018 DONE: done=1 for exactly that one cycle; start=1 -> accept new operands as in IDLE, go SHIFT (back-to-back); else go IDLE.
REQ-019 Latency: done SHALL be high in the cycle following the WIDTH-th rising edge after the accepting edge.
REQ-020 start during SHIFT SHALL be ignored; a, b, bin changes during SHIFT SHALL not affect the result.
REQ-021 diff and bout SHALL hold the last completed result in IDLE until the next accepting edge.
REQ-022 diff/bout SHALL be considered valid only when done=1 or in IDLE after a completed operation; intermediate values during SHIFT are don't-care.
REQ-023 busy SHALL equal (state == SHIFT); busy and done SHALL never be high together.

Reset
REQ-024 rst_n low SHALL immediately (asynchronously) force state IDLE, busy=0, done=0, diff=0, bout=0, counter=0, borrow reg=0, operand registers=0.
REQ-025 Reset asserted mid-SHIFT SHALL abandon the operation; no done pulse SHALL follow release.
REQ-026 After rst_n deasserts, the first start SHALL be accepted on the first rising edge where it is sampled high.

Structure
REQ-027 FSM state encodings (IDLE=2'd0, SHIFT=2'd1, DONE=2'd2) SHALL live in shared package serial_sub_pkg; counter width = $clog2(WIDTH+1) derived locally.
REQ-028 The 1-bit full-subtractor cell SHALL be a separate sub-module fs_cell (inputs a, b, bin; outputs d, bo), instantiated once.
REQ-029 The datapath SHALL contain no WIDTH-bit subtractor; only the single fs_cell performs arithmetic.

Verification (WIDTH=8)
REQ-030 a=0x5A, b=0x3C, bin=0, start 1 cycle -> busy 8 cycles, done pulse once, diff=0x1E, bout=0.
REQ-031 a=0x00, b=0x01, bin=0 -> diff=0xFF, bout=1; a=0x00, b=0xFF, bin=1 -> diff=0x00, bout=1.
REQ-032 start pulsed again at 3rd SHIFT cycle with a=0xFF, b=0x00 -> ignored; original result 0x1E/0 delivered.
REQ-033 start held high through DONE with new operands a=0x10, b=0x01 -> no IDLE cycle, second done 8 edges later, diff=0x0F, bout=0.
REQ-034 rst_n pulsed low at 4th SHIFT cycle -> outputs 0 immediately, no done, next start computes correctly.
REQ-035 WIDTH=2 exhaustive over all a, b, bin (32 cases) -> every result matches REQ-012, printed as a table.
